mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl -- CPU bus-cycle controller bridging a state-coded CPU bus
// (SYNC/STATE/DATA) to a 14-bit memory request port and a 32-port IO
// request port.
//
// Ports
//   CLK_I, nRST_I          system clock, async active-low reset
//   SYNC_I, STATE_I[2:0]   CPU state strobe and state code
//   DATA_I[7:0]            CPU bus output (addr low / addr high+type / wdata)
//   DATA_O[7:0]            read data to CPU at T3, 8'h00 otherwise
//   READY_O                low while a bus request is outstanding
//   MEM_*                  memory request port (addr, rd/wr strobes, data, ack)
//   IO_*                   IO request port (port, rd/wr strobes, data, ack)
//   INTA_O                 current cycle is an interrupt-acknowledge fetch
//   ERR_O                  sticky timeout/abort flag
//
// state  | meaning
// IDLE   | after reset, waiting for the first T1/T1I step
// ADDR   | low address latched, waiting for the T2 step
// WRWAIT | write cycle, waiting for the T3 step to supply write data
// BUSY   | one request strobe high, waiting for ack or timeout
// RDY    | request complete, read data available at T3

module mem_ctrl #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        CLK_I,
    input  logic        nRST_I,
    input  logic        SYNC_I,
    input  logic [2:0]  STATE_I,
    input  logic [7:0]  DATA_I,
    output logic [7:0]  DATA_O,
    output logic        READY_O,
    output logic [13:0] MEM_ADDR_O,
    output logic        MEM_RD_O,
    output logic        MEM_WR_O,
    output logic [7:0]  MEM_WDATA_O,
    input  logic [7:0]  MEM_RDATA_I,
    input  logic        MEM_ACK_I,
    output logic [4:0]  IO_PORT_O,
    output logic        IO_RD_O,
    output logic        IO_WR_O,
    output logic [7:0]  IO_WDATA_O,
    input  logic [7:0]  IO_RDATA_I,
    input  logic        IO_ACK_I,
    output logic        INTA_O,
    output logic        ERR_O
);

    localparam logic [2:0] ST_T1  = 3'b010;
    localparam logic [2:0] ST_T2  = 3'b100;
    localparam logic [2:0] ST_T3  = 3'b001;
    localparam logic [2:0] ST_T1I = 3'b110;

    localparam logic [1:0] PCI = 2'b00;
    localparam logic [1:0] PCC = 2'b01;
    localparam logic [1:0] PCR = 2'b10;
    localparam logic [1:0] PCW = 2'b11;

    localparam logic [7:0] TMO_LOAD = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, ADDR, WRWAIT, BUSY, RDY} stateT;

    stateT       state, nextState;
    logic        prevSync;
    logic [7:0]  addrL;
    logic [13:0] memAddr;
    logic [1:0]  cycType;
    logic        inta;
    logic [4:0]  ioPort;
    logic [7:0]  ioWdata;
    logic [7:0]  memWdata;
    logic [7:0]  rdata;
    logic        err;
    logic [7:0]  ackCnt;

    logic stepNow, t1Step, t2Step, t3Step;
    logic isMem, inPort, ack, ackTmo, outstanding, readType;

    assign stepNow     = SYNC_I & ~prevSync;
    assign t1Step      = stepNow & ((STATE_I == ST_T1) | (STATE_I == ST_T1I));
    assign t2Step      = stepNow & (STATE_I == ST_T2);
    assign t3Step      = stepNow & (STATE_I == ST_T3);
    assign isMem       = (cycType != PCC);
    assign inPort      = (ioPort[4:3] == 2'b00);
    assign ack         = isMem ? MEM_ACK_I : IO_ACK_I;
    // Ack on the terminal clock still wins over the timeout.
    assign ackTmo      = (state == BUSY) & ~ack & (ackCnt == 8'd1);
    assign outstanding = (state == WRWAIT) | (state == BUSY);
    assign readType    = (cycType != PCW) & ((cycType != PCC) | inPort);

    // State register
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a T1/T1I step always starts a new cycle.
    always_comb begin
        nextState = state;
        if (t1Step) begin
            nextState = ADDR;
        end else begin
            case (state)
                ADDR: begin
                    if (t2Step) begin
                        if (DATA_I[7:6] == PCW) begin
                            nextState = WRWAIT;
                        end else if ((DATA_I[7:6] == PCI) && inta) begin
                            nextState = RDY;
                        end else begin
                            nextState = BUSY;
                        end
                    end
                end
                WRWAIT: if (t3Step) nextState = BUSY;
                BUSY:   if (ack || ackTmo) nextState = RDY;
                default: nextState = state;
            endcase
        end
    end

    // Outputs decoded from state; strobes are mutually exclusive by type.
    always_comb begin
        MEM_RD_O = 1'b0;
        MEM_WR_O = 1'b0;
        IO_RD_O  = 1'b0;
        IO_WR_O  = 1'b0;
        DATA_O   = 8'h00;
        READY_O  = ~outstanding;
        if (state == BUSY) begin
            MEM_RD_O = (cycType == PCI) | (cycType == PCR);
            MEM_WR_O = (cycType == PCW);
            IO_RD_O  = (cycType == PCC) & inPort;
            IO_WR_O  = (cycType == PCC) & ~inPort;
        end
        if ((state == RDY) && (STATE_I == ST_T3) && readType) begin
            DATA_O = rdata;
        end
    end

    // Bus-cycle datapath and ack timer
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            prevSync <= 1'b0;
            addrL    <= 8'h00;
            memAddr  <= 14'h0000;
            cycType  <= PCI;
            inta     <= 1'b0;
            ioPort   <= 5'h00;
            ioWdata  <= 8'h00;
            memWdata <= 8'h00;
            rdata    <= 8'h00;
            err      <= 1'b0;
            ackCnt   <= 8'h00;
        end else begin
            prevSync <= SYNC_I;
            if (t1Step) begin
                addrL <= DATA_I;
                inta  <= (STATE_I == ST_T1I);
                if (outstanding) err <= 1'b1;
            end else if ((state == ADDR) && t2Step) begin
                memAddr <= {DATA_I[5:0], addrL};
                cycType <= DATA_I[7:6];
                if (DATA_I[7:6] == PCC) begin
                    ioPort <= DATA_I[5:1];
                    if (DATA_I[5:4] != 2'b00) ioWdata <= addrL;
                end
                // Interrupt acknowledge fetch is answered locally with RST 0.
                if ((DATA_I[7:6] == PCI) && inta) rdata <= 8'h05;
            end else if ((state == WRWAIT) && t3Step) begin
                memWdata <= DATA_I;
            end else if (state == BUSY) begin
                if (ack) begin
                    rdata <= isMem ? MEM_RDATA_I : IO_RDATA_I;
                end else if (ackTmo) begin
                    rdata <= 8'hFF;
                    err   <= 1'b1;
                end
            end

            if (nextState == BUSY) begin
                ackCnt <= (state == BUSY) ? (ackCnt - 8'd1) : TMO_LOAD;
            end else begin
                ackCnt <= 8'h00;
            end
        end
    end

    assign MEM_ADDR_O  = memAddr;
    assign MEM_WDATA_O = memWdata;
    assign IO_PORT_O   = ioPort;
    assign IO_WDATA_O  = ioWdata;
    assign INTA_O      = inta;
    assign ERR_O       = err;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int TMO = 4;
    localparam logic [2:0] C_T1   = 3'b010;
    localparam logic [2:0] C_T2   = 3'b100;
    localparam logic [2:0] C_T3   = 3'b001;
    localparam logic [2:0] C_T4   = 3'b111;
    localparam logic [2:0] C_T1I  = 3'b110;
    localparam logic [2:0] C_WAIT = 3'b000;
    localparam logic [63:0] RST_VIEW = 64'h1 << 49;

    logic        CLK_I = 1'b0;
    logic        nRST_I;
    logic        SYNC_I;
    logic [2:0]  STATE_I;
    logic [7:0]  DATA_I;
    logic [7:0]  DATA_O;
    logic        READY_O;
    logic [13:0] MEM_ADDR_O;
    logic        MEM_RD_O, MEM_WR_O;
    logic [7:0]  MEM_WDATA_O;
    logic [7:0]  MEM_RDATA_I;
    logic        MEM_ACK_I;
    logic [4:0]  IO_PORT_O;
    logic        IO_RD_O, IO_WR_O;
    logic [7:0]  IO_WDATA_O;
    logic [7:0]  IO_RDATA_I;
    logic        IO_ACK_I;
    logic        INTA_O, ERR_O;

    always #5 CLK_I = ~CLK_I;

    mem_ctrl #(.ACK_TIMEOUT(TMO)) dut (
        .CLK_I(CLK_I), .nRST_I(nRST_I), .SYNC_I(SYNC_I), .STATE_I(STATE_I),
        .DATA_I(DATA_I), .DATA_O(DATA_O), .READY_O(READY_O),
        .MEM_ADDR_O(MEM_ADDR_O), .MEM_RD_O(MEM_RD_O), .MEM_WR_O(MEM_WR_O),
        .MEM_WDATA_O(MEM_WDATA_O), .MEM_RDATA_I(MEM_RDATA_I), .MEM_ACK_I(MEM_ACK_I),
        .IO_PORT_O(IO_PORT_O), .IO_RD_O(IO_RD_O), .IO_WR_O(IO_WR_O),
        .IO_WDATA_O(IO_WDATA_O), .IO_RDATA_I(IO_RDATA_I), .IO_ACK_I(IO_ACK_I),
        .INTA_O(INTA_O), .ERR_O(ERR_O)
    );

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory/IO responder: acks after the strobe has been high 'lat' clocks
    // (lat = 0 never acks) and records what the strobes did.
    int         lat = 0;
    int         hiCnt = 0;
    int         peak = 0;
    int         multiHot = 0;
    logic [3:0] seenMask = 4'b0;
    logic       ackNow;

    always @(negedge CLK_I) begin
        logic [3:0] s;
        s = {IO_WR_O, IO_RD_O, MEM_WR_O, MEM_RD_O};
        if (|s) begin
            hiCnt++;
            if (hiCnt > peak) peak = hiCnt;
            seenMask = seenMask | s;
            if (!$onehot(s)) multiHot++;
        end else begin
            hiCnt = 0;
        end
        ackNow    = (|s) && (lat != 0) && (hiCnt == lat);
        MEM_ACK_I = ackNow && (s[0] || s[1]);
        IO_ACK_I  = ackNow && (s[2] || s[3]);
    end

    bit errModel;

    function automatic logic [63:0] rstView();
        return {14'b0, READY_O, DATA_O, MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O,
                MEM_ADDR_O, IO_PORT_O, MEM_WDATA_O, IO_WDATA_O, INTA_O, ERR_O};
    endfunction

    task automatic step(input logic [2:0] code, input logic [7:0] d);
        @(negedge CLK_I);
        STATE_I = code;
        DATA_I  = d;
        SYNC_I  = 1'b1;
        @(negedge CLK_I);
        SYNC_I  = 1'b0;
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (!READY_O && n < 40) begin
            @(negedge CLK_I);
            n++;
        end
        checkEq(tag, 64'(READY_O), 64'(1));
    endtask

    task automatic doReset();
        @(negedge CLK_I);
        nRST_I = 1'b0;
        @(negedge CLK_I);
        nRST_I = 1'b1;
        errModel = 1'b0;
    endtask

    // One complete CPU bus cycle; expectations come straight from the
    // cycle-type rules: which strobe, how long, what the CPU reads back.
    task automatic runCycle(input bit intr, input logic [1:0] typ, input logic [7:0] lo,
                            input logic [5:0] hi, input logic [7:0] wd,
                            input logic [7:0] rd, input int latency);
        bit         skip, timedOut, readType, outPort;
        int         expHi;
        logic [3:0] expMask;
        logic [7:0] expData;
        skip     = intr && (typ == 2'd0);
        outPort  = (hi[5:4] != 2'b00);
        timedOut = !skip && (latency == 0 || latency > TMO);
        expHi    = skip ? 0 : (timedOut ? TMO : latency);
        case (typ)
            2'd0, 2'd2: expMask = 4'b0001;
            2'd3:       expMask = 4'b0010;
            default:    expMask = outPort ? 4'b1000 : 4'b0100;
        endcase
        if (skip) expMask = 4'b0000;
        readType = (typ != 2'd3) && !(typ == 2'd1 && outPort);
        expData  = !readType ? 8'h00 : (skip ? 8'h05 : (timedOut ? 8'hFF : rd));
        if (timedOut) errModel = 1'b1;

        lat         = latency;
        MEM_RDATA_I = (typ == 2'd1) ? ~rd : rd;
        IO_RDATA_I  = (typ == 2'd1) ? rd : ~rd;
        peak        = 0;
        seenMask    = 4'b0;

        step(intr ? C_T1I : C_T1, lo);
        checkEq("inta", 64'(INTA_O), 64'(intr));
        step(C_T2, {typ, hi});
        checkEq("memAddr", 64'(MEM_ADDR_O), 64'({hi, lo}));
        checkEq("readyAfterT2", 64'(READY_O), 64'(skip));
        if (typ == 2'd3) begin
            step(C_T3, wd);
            waitReady("writeDone");
        end else begin
            waitReady("readDone");
            step(C_T3, 8'h00);
        end
        checkEq("dataT3", 64'(DATA_O), 64'(expData));
        checkEq("strobeClks", 64'(peak), 64'(expHi));
        checkEq("strobeKind", 64'(seenMask), 64'(expMask));
        checkEq("err", 64'(ERR_O), 64'(errModel));
        if (typ == 2'd3) checkEq("memWdata", 64'(MEM_WDATA_O), 64'(wd));
        if (typ == 2'd1) begin
            checkEq("ioPort", 64'(IO_PORT_O), 64'(hi[5:1]));
            if (outPort) checkEq("ioWdata", 64'(IO_WDATA_O), 64'(lo));
        end
        step(C_T4, 8'h00);
        checkEq("dataT4", 64'(DATA_O), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nRST_I      = 1'b0;
        SYNC_I      = 1'b0;
        STATE_I     = C_WAIT;
        DATA_I      = 8'h00;
        MEM_RDATA_I = 8'h00;
        IO_RDATA_I  = 8'h00;
        MEM_ACK_I   = 1'b0;
        IO_ACK_I    = 1'b0;
        errModel    = 1'b0;
        #2;
        checkEq("resetView", rstView(), RST_VIEW);
        @(negedge CLK_I);
        nRST_I = 1'b1;

        // Out-of-sequence T2 step in IDLE must be ignored.
        step(C_T2, 8'h92);
        checkEq("ignoreReady", 64'(READY_O), 64'(1));
        checkEq("ignoreRd", 64'(MEM_RD_O), 64'(0));

        runCycle(1'b0, 2'b00, 8'h34, 6'h12, 8'h00, 8'h7C, 3);   // fetch 1234h
        runCycle(1'b0, 2'b11, 8'h00, 6'h05, 8'hA9, 8'h00, 1);   // write 0500h
        runCycle(1'b0, 2'b01, 8'h3C, 6'h12, 8'h00, 8'h00, 2);   // IO out port 9
        runCycle(1'b0, 2'b01, 8'h3C, 6'h06, 8'h00, 8'hE1, 2);   // IO in port 3
        runCycle(1'b1, 2'b00, 8'h00, 6'h00, 8'h00, 8'h99, 2);   // interrupt ack
        runCycle(1'b0, 2'b10, 8'h55, 6'h2A, 8'h00, 8'h11, TMO); // ack on last clock
        runCycle(1'b0, 2'b10, 8'h55, 6'h2A, 8'h00, 8'h11, 0);   // timeout

        for (int i = 0; i < 30; i++) begin
            runCycle($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                     8'($urandom), 6'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 6)));
        end

        // New T1 while a read is outstanding aborts it.
        doReset();
        checkEq("errCleared", 64'(ERR_O), 64'(0));
        lat = 0;
        step(C_T1, 8'h10);
        step(C_T2, {2'b10, 6'h01});
        checkEq("abortRdBefore", 64'(MEM_RD_O), 64'(1));
        step(C_T1, 8'h20);
        checkEq("abortRdAfter", 64'(MEM_RD_O), 64'(0));
        checkEq("abortErr", 64'(ERR_O), 64'(1));
        errModel = 1'b1;
        runCycle(1'b0, 2'b10, 8'h20, 6'h03, 8'h00, 8'h66, 2);

        // Reset in the middle of a read takes effect without a clock.
        lat = 0;
        step(C_T1, 8'hAB);
        step(C_T2, {2'b10, 6'h3F});
        @(negedge CLK_I);
        checkEq("midReadRd", 64'(MEM_RD_O), 64'(1));
        #3;
        nRST_I = 1'b0;
        #1;
        checkEq("midReadReset", rstView(), RST_VIEW);
        @(negedge CLK_I);
        nRST_I   = 1'b1;
        errModel = 1'b0;
        runCycle(1'b0, 2'b00, 8'hC3, 6'h21, 8'h00, 8'h5A, 2);

        checkEq("oneStrobe", 64'(multiHot), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
